// File: rtl/piso_pkg.sv
// Shared state encoding for the parallel-in/serial-out transmitter.
package piso_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SHIFT  = 2'd1;
    localparam logic [1:0] ST_PARITY = 2'd2;

endpackage

// File: rtl/piso_tx.sv
// Parallel-in, serial-out transmitter, MSB first, valid/ready load handshake.
// Optional trailing even-parity bit when PISO_TX_PARITY_EN is defined.
module piso_tx
    import piso_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_valid,
    output logic         load_ready,
    input  logic [N-1:0] D,
    output logic         sdo,
    output logic         sdo_valid,
    output logic         sdo_last,
    output logic         busy
);

    localparam int CNT_W = $clog2(N + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

`ifdef PISO_TX_PARITY_EN
    localparam logic PARITY_EN = 1'b1;
`else
    localparam logic PARITY_EN = 1'b0;
`endif

    function automatic logic even_parity(input logic [N-1:0] word);
        return ^word;
    endfunction

    logic [1:0]       state_r;
    logic [1:0]       state_nx_s;
    logic [N-1:0]     shift_r;
    logic [N-1:0]     shift_nx_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nx_s;
    logic             last_bit_s;
    logic             accept_s;
`ifdef PISO_TX_PARITY_EN
    logic             parity_r;
    logic             parity_nx_s;
`endif

    assign last_bit_s = (cnt_r == LAST_CNT);
    assign accept_s   = load_valid & load_ready;

    // Output decode: every output comes from state registers only, never from D.
    always_comb begin
        load_ready = 1'b0;
        sdo        = 1'b0;
        sdo_valid  = 1'b0;
        sdo_last   = 1'b0;
        busy       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                load_ready = 1'b1;
            end
            ST_SHIFT: begin
                sdo       = shift_r[N-1];
                sdo_valid = 1'b1;
                busy      = 1'b1;
                if (last_bit_s) begin
                    sdo_last   = ~PARITY_EN;
                    load_ready = ~PARITY_EN;
                end else begin
                    sdo_last   = 1'b0;
                    load_ready = 1'b0;
                end
            end
`ifdef PISO_TX_PARITY_EN
            ST_PARITY: begin
                sdo        = parity_r;
                sdo_valid  = 1'b1;
                sdo_last   = 1'b1;
                load_ready = 1'b1;
                busy       = 1'b1;
            end
`endif
            default: begin
                load_ready = 1'b0;
            end
        endcase
    end

    // Next-state logic for FSM, shift register, bit counter and parity.
    always_comb begin
        state_nx_s  = state_r;
        shift_nx_s  = shift_r;
        cnt_nx_s    = cnt_r;
`ifdef PISO_TX_PARITY_EN
        parity_nx_s = parity_r;
`endif
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nx_s  = ST_SHIFT;
                    shift_nx_s  = D;
                    cnt_nx_s    = '0;
`ifdef PISO_TX_PARITY_EN
                    parity_nx_s = even_parity(D);
`endif
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (last_bit_s) begin
`ifdef PISO_TX_PARITY_EN
                    state_nx_s = ST_PARITY;
                    shift_nx_s = {shift_r[N-2:0], 1'b0};
                    cnt_nx_s   = '0;
`else
                    // Reload on the final bit keeps frames back-to-back with no bubble.
                    if (accept_s) begin
                        state_nx_s = ST_SHIFT;
                        shift_nx_s = D;
                        cnt_nx_s   = '0;
                    end else begin
                        state_nx_s = ST_IDLE;
                        shift_nx_s = {shift_r[N-2:0], 1'b0};
                        cnt_nx_s   = '0;
                    end
`endif
                end else begin
                    shift_nx_s = {shift_r[N-2:0], 1'b0};
                    cnt_nx_s   = cnt_r + CNT_ONE;
                end
            end
`ifdef PISO_TX_PARITY_EN
            ST_PARITY: begin
                if (accept_s) begin
                    state_nx_s  = ST_SHIFT;
                    shift_nx_s  = D;
                    cnt_nx_s    = '0;
                    parity_nx_s = even_parity(D);
                end else begin
                    state_nx_s  = ST_IDLE;
                end
            end
`endif
            default: begin
                state_nx_s = ST_IDLE;
                shift_nx_s = '0;
                cnt_nx_s   = '0;
            end
        endcase
    end

    // State registers with asynchronous active-high reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            shift_r <= '0;
            cnt_r   <= '0;
        end else begin
            state_r <= state_nx_s;
            shift_r <= shift_nx_s;
            cnt_r   <= cnt_nx_s;
        end
    end

`ifdef PISO_TX_PARITY_EN
    // Parity bit captured alongside the data word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parity_r <= 1'b0;
        end else begin
            parity_r <= parity_nx_s;
        end
    end
`endif

endmodule

// File: tb/tb_piso_tx.sv
// Directed self-checking bench for piso_tx at N=4 and N=8; follows PISO_TX_PARITY_EN.
module tb_piso_tx;

`ifdef PISO_TX_PARITY_EN
    localparam logic PAR = 1'b1;
`else
    localparam logic PAR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       lv4, lr4, sdo4, v4, l4, busy4;
    logic [3:0] d4;
    logic       lv8, lr8, sdo8, v8, l8, busy8;
    logic [7:0] d8;
    int         n_checks = 0;
    int         n_errors = 0;

    always #5 clk = ~clk;

    piso_tx #(.N(4)) dut4 (
        .clk(clk), .rst(rst), .load_valid(lv4), .load_ready(lr4), .D(d4),
        .sdo(sdo4), .sdo_valid(v4), .sdo_last(l4), .busy(busy4)
    );

    piso_tx #(.N(8)) dut8 (
        .clk(clk), .rst(rst), .load_valid(lv8), .load_ready(lr8), .D(d8),
        .sdo(sdo8), .sdo_valid(v8), .sdo_last(l8), .busy(busy8)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle4(input string tag);
        check({tag, " busy"}, {31'd0, busy4}, 32'd0);
        check({tag, " valid"}, {31'd0, v4}, 32'd0);
        check({tag, " sdo"}, {31'd0, sdo4}, 32'd0);
        check({tag, " last"}, {31'd0, l4}, 32'd0);
        check({tag, " ready"}, {31'd0, lr4}, 32'd1);
    endtask

    // One isolated frame on the 4-bit instance; bits are the word MSB first.
    task automatic run4(input string tag, input logic [3:0] w, input logic exp_par);
        lv4 = 1'b1;
        d4  = w;
        step();
        lv4 = 1'b0;
        d4  = 4'h0;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("%s bit%0d", tag, k), {31'd0, sdo4}, {31'd0, w[3-k]});
            check($sformatf("%s valid%0d", tag, k), {31'd0, v4}, 32'd1);
            check($sformatf("%s busy%0d", tag, k), {31'd0, busy4}, 32'd1);
            check($sformatf("%s last%0d", tag, k), {31'd0, l4}, {31'd0, (k == 3) && !PAR});
            check($sformatf("%s ready%0d", tag, k), {31'd0, lr4}, {31'd0, (k == 3) && !PAR});
            step();
        end
        if (PAR) begin
            check({tag, " parity"}, {31'd0, sdo4}, {31'd0, exp_par});
            check({tag, " par valid"}, {31'd0, v4}, 32'd1);
            check({tag, " par last"}, {31'd0, l4}, 32'd1);
            check({tag, " par ready"}, {31'd0, lr4}, 32'd1);
            step();
        end
        check_idle4({tag, " end"});
    endtask

    initial begin
        logic [9:0] b2b_exp;
        int         b2b_len;
        logic [7:0] w8;

        rst = 1'b1;
        lv4 = 1'b0;
        d4  = 4'h0;
        lv8 = 1'b0;
        d8  = 8'h00;
        #12;
        check_idle4("reset");
        check("reset busy8", {31'd0, busy8}, 32'd0);
        check("reset ready8", {31'd0, lr8}, 32'd1);
        step();
        rst = 1'b0;
        step();

        // Basic frame and parity patterns.
        run4("basic", 4'b1011, 1'b1);
        run4("par0111", 4'b0111, 1'b1);
        run4("par0110", 4'b0110, 1'b0);

        // Back-to-back: A then 5 with load_valid held; reload on the final cycle.
        b2b_exp = PAR ? 10'b1010001010 : 10'b0010100101;
        b2b_len = PAR ? 10 : 8;
        lv4 = 1'b1;
        d4  = 4'hA;
        step();
        d4 = 4'h5;
        for (int k = 0; k < b2b_len; k++) begin
            check($sformatf("b2b bit%0d", k), {31'd0, sdo4}, {31'd0, b2b_exp[b2b_len-1-k]});
            check($sformatf("b2b valid%0d", k), {31'd0, v4}, 32'd1);
            check($sformatf("b2b last%0d", k), {31'd0, l4},
                  {31'd0, (k == b2b_len / 2 - 1) || (k == b2b_len - 1)});
            step();
            if (k == b2b_len / 2 - 1) begin
                lv4 = 1'b0;
                d4  = 4'h0;
            end
        end
        check_idle4("b2b end");

        // Load offered mid-frame is ignored.
        lv4 = 1'b1;
        d4  = 4'h3;
        step();
        lv4 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("busyload bit%0d", k), {31'd0, sdo4}, {31'd0, k >= 2});
            if (k == 1) begin
                check("busyload ready", {31'd0, lr4}, 32'd0);
                lv4 = 1'b1;
                d4  = 4'hF;
            end
            step();
            if (k == 1) begin
                lv4 = 1'b0;
                d4  = 4'h0;
            end
        end
        if (PAR) begin
            check("busyload parity", {31'd0, sdo4}, 32'd0);
            step();
        end
        check_idle4("busyload end");

        // Asynchronous reset mid-frame, then a clean fresh frame.
        lv4 = 1'b1;
        d4  = 4'hC;
        step();
        lv4 = 1'b0;
        check("rstmid bit0", {31'd0, sdo4}, 32'd1);
        step();
        check("rstmid bit1", {31'd0, sdo4}, 32'd1);
        check("rstmid busy", {31'd0, busy4}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_idle4("rstmid async");
        step();
        rst = 1'b0;
        check_idle4("rstmid released");
        run4("after rst", 4'h9, 1'b0);

        // Width override: 8-bit instance.
        w8  = 8'h81;
        lv8 = 1'b1;
        d8  = w8;
        step();
        lv8 = 1'b0;
        for (int k = 0; k < 8; k++) begin
            check($sformatf("n8 bit%0d", k), {31'd0, sdo8}, {31'd0, w8[7-k]});
            check($sformatf("n8 valid%0d", k), {31'd0, v8}, 32'd1);
            check($sformatf("n8 last%0d", k), {31'd0, l8}, {31'd0, (k == 7) && !PAR});
            step();
        end
        if (PAR) begin
            check("n8 parity", {31'd0, sdo8}, 32'd0);
            check("n8 par last", {31'd0, l8}, 32'd1);
            step();
        end
        check("n8 end busy", {31'd0, busy8}, 32'd0);
        check("n8 end valid", {31'd0, v8}, 32'd0);
        check("n8 end ready", {31'd0, lr8}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/piso_tx.md
Name: piso_tx

Overview:
- Parallel-in, serial-out transmitter. It is the read/consume side of the team's N-bit parallel D register.
- Accepts an N-bit word through a valid/ready handshake and shifts it out one bit per clock, MSB first.
- Drives a serial-valid qualifier and a last-bit marker.
- Sits between a parallel register stage and any 1-bit serial sink (deserializer, LED/shift chain, UART-style framer).

Parameters:
- N, 4, data word width in bits (N >= 2).
- CNT_W, $clog2(N+1), bit-counter width. Local, derived, not overridable.

Ports:
- clk  input  1  clock, rising-edge active
- rst  input  1  reset, asynchronous, active-high
- load_valid  input  1  parallel word on D is offered this cycle
- load_ready  output  1  block can accept a word this cycle
- D  input  N  parallel data word, sampled when load_valid && load_ready
- sdo  output  1  serial data out
- sdo_valid  output  1  sdo carries a valid bit this cycle
- sdo_last  output  1  current sdo bit is the final bit of the frame
- busy  output  1  a frame is in progress (state != IDLE)

Behaviour:
- Reset: rst is asynchronous and active-high; clk is the clock. On rst assertion, immediately:
  - state=IDLE, shift register=0, counter=0
  - sdo=0, sdo_valid=0, sdo_last=0, busy=0
  - load_ready=1 (decoded from IDLE), but no load is accepted while rst is high.
- Reset mid-frame: the frame is abandoned, no further bits are emitted, and the next accepted word starts a fresh frame.
- States: IDLE, SHIFT, PARITY (PARITY exists only with the optional feature).
- IDLE:
  - load_ready=1, sdo_valid=0, sdo=0.
  - On a posedge with load_valid=1: latch D into the shift register, counter=0, go to SHIFT.
- SHIFT:
  - sdo = shift_reg[N-1] (registered state, no combinational path from D).
  - sdo_valid=1.
  - Each posedge: shift left by 1 with zero fill, counter+1.
- Latency: the first bit appears on sdo in the cycle after the accepting edge. Bit k (MSB = 0) appears k+1 cycles after acceptance.
- Last data bit (counter == N-1):
  - Without parity: sdo_last=1 and load_ready=1 in this cycle.
    - Load accepted on this edge: reload shift register, counter=0, stay in SHIFT (back-to-back, no bubble, throughput N cycles/word).
    - Otherwise go to IDLE.
  - With parity: go to PARITY; load_ready=0 in this cycle.
- load_ready is 0 in SHIFT except on the final-bit cycle. load_valid while load_ready=0 is ignored, and D is not sampled.
- load_valid may drop without acceptance; there is no stickiness requirement on the source.
- Counter never exceeds N-1 in SHIFT. No wrap-around state is reachable.
- busy=1 in SHIFT and PARITY.

Optional Feature:
- Macro: PISO_TX_PARITY_EN.
- Defined:
  - Even parity (reduction XOR of D) is computed and stored at load.
  - After the N data bits, one PARITY cycle drives sdo=parity, sdo_valid=1, sdo_last=1, load_ready=1.
  - Same back-to-back reload rule as the final-bit cycle; frame length N+1 cycles.
  - sdo_last is 0 on the Nth data bit.
- Undefined:
  - No PARITY state, no parity register, frame length N, sdo_last on the Nth data bit.

Decomposition:
- Shared package/header piso_pkg:
  - state encoding constants ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_PARITY=2'd2.
- No sub-module. Shift register, counter and FSM form one always block pair; parity is a single reduction XOR.
- The existing parallel D register may be instantiated upstream by the integrator, not inside this block.

Test Plan:
- Basic frame, N=4: D=4'b1011 with load_valid pulsed 1 cycle in IDLE -> sdo=1,0,1,1 on cycles +1..+4; sdo_valid=1 on those cycles only; sdo_last=1 only at +4; busy=0 at +5.
- Back-to-back: hold load_valid=1 with D=4'hA then 4'h5, the second accepted on the final-bit cycle -> continuous 8 valid bits 1,0,1,0,0,1,0,1 with no idle cycle.
- Load while busy: assert load_valid with D=4'hF at cycle +2 of frame 4'h3 -> ignored; output stays 0,0,1,1; load_ready=0 at +2.
- Reset mid-frame: assert rst at cycle +2 of 4'hC -> sdo=0, sdo_valid=0, busy=0 immediately (asynchronously); after release, load 4'h9 -> 1,0,0,1 emitted cleanly.
- Parity (PISO_TX_PARITY_EN defined):
  - D=4'b0111 -> 0,1,1,1 then parity bit 1; sdo_last on the 5th bit only.
  - D=4'b0110 -> parity bit 0.
- Width override, N=8: D=8'h81 -> 1,0,0,0,0,0,0,1; sdo_last at the 8th bit; counter reaches 7 only.
